id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the pipelined RV32 core; sits directly upstream of the execute-stage ALU.
- Captures decoded operands and control each cycle, then resolves EX/MEM and MEM/WB data forwarding after the register.
- Drives ALU_SRC_A, ALU_SRC_B and ALU_FUN straight into the ALU.
- Detects load-use hazards, inserts bubbles, and honours pipeline stall and flush.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  global freeze, e.g. memory wait.
- FLUSH  in  1  squash the instruction entering EX (taken branch/jump).
- ID_VALID  in  1  ID holds a real instruction.
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  RA_W  register addresses.
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register-file read data.
- ID_IMM  in  XLEN  sign-extended immediate.
- ID_SRCB_IMM  in  1  1 = ALU B uses immediate, 0 = rs2.
- ID_USES_RS2  in  1  instruction reads rs2 (R-type, store, branch).
- ID_ALU_FUN  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  in  1  control.
- EXMEM_RD_ADDR, MEMWB_RD_ADDR  in  RA_W  downstream destinations.
- EXMEM_REG_WRITE, MEMWB_REG_WRITE  in  1  downstream write enables.
- EXMEM_RESULT, MEMWB_RESULT  in  XLEN  downstream results.
- LU_HAZARD  out  1  combinational load-use stall request to IF/ID.
- EX_VALID  out  1  EX holds a real instruction.
- ALU_SRC_A, ALU_SRC_B  out  XLEN  forwarded ALU operands.
- ALU_FUN  out  3  registered ALU function.
- EX_STORE_DATA  out  XLEN  forwarded rs2 for stores.
- EX_RD_ADDR  out  RA_W.
- EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  1  control to EX/MEM.

Behaviour:
- Reset (RST_N low, asynchronous): all registered fields clear to 0, giving a bubble (EX_VALID=0, ALU_FUN=000, operands 0, controls 0).
  - Reset mid-operation discards the held instruction immediately, not at the next edge.
- Register update each rising edge, in this priority order:
  - STALL=1: hold all fields; FLUSH and LU_HAZARD are ignored that cycle. Upstream keeps FLUSH asserted until a non-stalled edge.
  - FLUSH=1: load bubble.
  - LU_HAZARD=1: load bubble. IF/ID holds, so the consumer re-enters next cycle (exactly one bubble).
  - Otherwise: load ID fields. EX_VALID <= ID_VALID. Control enables are ANDed with ID_VALID.
- LU_HAZARD = EX_VALID & EX_MEM_READ & EX_REG_WRITE & (EX_RD_ADDR!=0) & ID_VALID & ((ID_RS1_ADDR==EX_RD_ADDR) | (ID_USES_RS2 & ID_RS2_ADDR==EX_RD_ADDR)).
- Forwarding is combinational after the register and stays live during STALL. Applied per operand (rs1, rs2):
  - Forward EXMEM_RESULT if EXMEM_REG_WRITE, EXMEM_RD_ADDR!=0 and the address matches.
  - Else forward MEMWB_RESULT under the same conditions on MEMWB.
  - Else use the registered register-file data.
  - x0 is never forwarded.
- Operand outputs:
  - ALU_SRC_A = forwarded rs1.
  - ALU_SRC_B = registered imm if SRCB_IMM, else forwarded rs2.
  - EX_STORE_DATA = forwarded rs2 always.
- Illegal ID_ALU_FUN (100, 110, 111) is passed through unchanged; the ALU flags it via its default result.
- Same-cycle WB write versus ID read is resolved by register-file write-through and is outside this block.
- Latency: one cycle from ID capture to ALU operands.

Decomposition:
- core_pkg holds:
  - alu_fun_t enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101).
  - id_ex_t packed struct of the registered fields.
  - BUBBLE constant of type id_ex_t.
- One sub-module, fwd_mux: one instance per source register. Inputs are the address, registered data and both downstream ports; output is the forwarded data.

Test Plan:
- Reset: RST_N low mid-cycle with a valid instruction held -> EX_VALID=0, ALU_FUN=000 and ALU_SRC_A=0 immediately, before any clock edge.
- Forward priority: EX rs1=x5; EXMEM rd=x5 result 0x11; MEMWB rd=x5 result 0x22 -> ALU_SRC_A=0x11. Drop EXMEM_REG_WRITE -> ALU_SRC_A=0x22.
- x0 guard: rs2=x0, EXMEM rd=x0 with write enabled and result 0xDEAD, SRCB_IMM=0 -> ALU_SRC_B=registered rs2 data (0).
- Load-use: lw x3 in EX, add rs1=x3 in ID -> LU_HAZARD=1 for one cycle, then a bubble (EX_VALID=0), then the add with ALU_SRC_A=MEMWB load data.
- Stall beats flush: STALL=1 and FLUSH=1 together -> fields held and EX_VALID unchanged. Next edge with STALL=0, FLUSH=1 -> bubble.
- Immediate path: ID_SRCB_IMM=1, ID_IMM=0xFFFFFFFC, ID_ALU_FUN=101 -> after one edge ALU_SRC_B=0xFFFFFFFC, ALU_FUN=101, EX_STORE_DATA=forwarded rs2.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the RV32 ID/EX operand stage: ALU function codes and
// the layout of the ID/EX pipeline register.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_RA_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_fun_t;

  // alu_fun is kept as raw bits so illegal codes reach the ALU unchanged.
  typedef struct packed {
    logic                 valid;
    logic [CORE_RA_W-1:0] rs1_addr;
    logic [CORE_RA_W-1:0] rs2_addr;
    logic [CORE_RA_W-1:0] rd_addr;
    logic [CORE_XLEN-1:0] rs1_data;
    logic [CORE_XLEN-1:0] rs2_data;
    logic [CORE_XLEN-1:0] imm;
    logic                 srcb_imm;
    logic [2:0]           alu_fun;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Forwarding bus from the EX/MEM and MEM/WB pipeline registers back into EX.
interface id_ex_operand_stage_if
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int RA_W = CORE_RA_W
);
  logic [RA_W-1:0] EXMEM_RD_ADDR;
  logic            EXMEM_REG_WRITE;
  logic [XLEN-1:0] EXMEM_RESULT;
  logic [RA_W-1:0] MEMWB_RD_ADDR;
  logic            MEMWB_REG_WRITE;
  logic [XLEN-1:0] MEMWB_RESULT;

  // master: downstream stages publishing results; slave: the EX operand stage.
  modport master (
    output EXMEM_RD_ADDR, EXMEM_REG_WRITE, EXMEM_RESULT,
    output MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_RESULT
  );
  modport slave (
    input EXMEM_RD_ADDR, EXMEM_REG_WRITE, EXMEM_RESULT,
    input MEMWB_RD_ADDR, MEMWB_REG_WRITE, MEMWB_RESULT
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source-register forwarding select: EX/MEM beats MEM/WB beats the
// registered register-file value; x0 is never forwarded.
module id_ex_operand_stage_fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int RA_W = CORE_RA_W
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);
  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs_addr);
  assign hit_memwb = memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs_addr);

  always_comb begin
    fwd_data = rs_data;
    if (hit_exmem)      fwd_data = exmem_result;
    else if (hit_memwb) fwd_data = memwb_result;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with post-register forwarding and load-use
// hazard detection, feeding the execute-stage ALU directly.
module id_ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int RA_W = CORE_RA_W
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            ID_VALID,
  input  logic [RA_W-1:0] ID_RS1_ADDR,
  input  logic [RA_W-1:0] ID_RS2_ADDR,
  input  logic [RA_W-1:0] ID_RD_ADDR,
  input  logic [XLEN-1:0] ID_RS1_DATA,
  input  logic [XLEN-1:0] ID_RS2_DATA,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic            ID_SRCB_IMM,
  input  logic            ID_USES_RS2,
  input  logic [2:0]      ID_ALU_FUN,
  input  logic            ID_REG_WRITE,
  input  logic            ID_MEM_READ,
  input  logic            ID_MEM_WRITE,
  id_ex_operand_stage_if.slave FWD,
  output logic            LU_HAZARD,
  output logic            EX_VALID,
  output logic [XLEN-1:0] ALU_SRC_A,
  output logic [XLEN-1:0] ALU_SRC_B,
  output logic [2:0]      ALU_FUN,
  output logic [XLEN-1:0] EX_STORE_DATA,
  output logic [RA_W-1:0] EX_RD_ADDR,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE
);
  // Valid semantics: EX_VALID marks a real instruction in EX; a bubble has
  // every field zero, so no control enable can fire. There is no ready path:
  // STALL freezes this register and LU_HAZARD tells IF/ID to hold.
  id_ex_t ex_q, ex_d;
  id_ex_t id_word;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    id_word           = BUBBLE;
    id_word.valid     = ID_VALID;
    id_word.rs1_addr  = ID_RS1_ADDR;
    id_word.rs2_addr  = ID_RS2_ADDR;
    id_word.rd_addr   = ID_RD_ADDR;
    id_word.rs1_data  = ID_RS1_DATA;
    id_word.rs2_data  = ID_RS2_DATA;
    id_word.imm       = ID_IMM;
    id_word.srcb_imm  = ID_SRCB_IMM;
    id_word.alu_fun   = ID_ALU_FUN;
    id_word.reg_write = ID_REG_WRITE & ID_VALID;
    id_word.mem_read  = ID_MEM_READ  & ID_VALID;
    id_word.mem_write = ID_MEM_WRITE & ID_VALID;
  end

  assign LU_HAZARD = ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                     (ex_q.rd_addr != '0) && ID_VALID &&
                     ((ID_RS1_ADDR == ex_q.rd_addr) ||
                      (ID_USES_RS2 && (ID_RS2_ADDR == ex_q.rd_addr)));

  always_comb begin
    ex_d = ex_q;
    if (STALL)          ex_d = ex_q;
    else if (FLUSH)     ex_d = BUBBLE;
    else if (LU_HAZARD) ex_d = BUBBLE;
    else                ex_d = id_word;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ex_q <= BUBBLE;
    else        ex_q <= ex_d;
  end

  id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_addr         (ex_q.rs1_addr),
    .rs_data         (ex_q.rs1_data),
    .exmem_rd_addr   (FWD.EXMEM_RD_ADDR),
    .exmem_reg_write (FWD.EXMEM_REG_WRITE),
    .exmem_result    (FWD.EXMEM_RESULT),
    .memwb_rd_addr   (FWD.MEMWB_RD_ADDR),
    .memwb_reg_write (FWD.MEMWB_REG_WRITE),
    .memwb_result    (FWD.MEMWB_RESULT),
    .fwd_data        (rs1_fwd)
  );

  id_ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_addr         (ex_q.rs2_addr),
    .rs_data         (ex_q.rs2_data),
    .exmem_rd_addr   (FWD.EXMEM_RD_ADDR),
    .exmem_reg_write (FWD.EXMEM_REG_WRITE),
    .exmem_result    (FWD.EXMEM_RESULT),
    .memwb_rd_addr   (FWD.MEMWB_RD_ADDR),
    .memwb_reg_write (FWD.MEMWB_REG_WRITE),
    .memwb_result    (FWD.MEMWB_RESULT),
    .fwd_data        (rs2_fwd)
  );

  assign EX_VALID      = ex_q.valid;
  assign ALU_SRC_A     = rs1_fwd;
  assign ALU_SRC_B     = ex_q.srcb_imm ? ex_q.imm : rs2_fwd;
  assign ALU_FUN       = ex_q.alu_fun;
  assign EX_STORE_DATA = rs2_fwd;
  assign EX_RD_ADDR    = ex_q.rd_addr;
  assign EX_REG_WRITE  = ex_q.reg_write;
  assign EX_MEM_READ   = ex_q.mem_read;
  assign EX_MEM_WRITE  = ex_q.mem_write;
endmodule
